// File: rtl/dm_bridge_pkg.sv
// Shared types and defaults for the data-memory bus bridge.
// Controller state encoding and the default abort limit live here.
package dm_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/dm_bridge_wait_timer.sv
// Wait counter for an outstanding bus access.
// expired flags the cycle in which the count would reach TIMEOUT.
module wait_timer
    import dm_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign expired = enable && w_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_bridge.sv
// Bridges the core's single-cycle data-memory strobe onto a req/ack bus.
// One access in flight; reads that time out return zero and flag an error.
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_enable,
    input  logic              DM_read,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_address,
    input  logic [DATA_W-1:0] DM_in,
    output logic [DATA_W-1:0] DM_out,
    output logic              dm_stall,
    output logic              dm_error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t r_state;
    logic   w_valid;
    logic   w_conflict;
    logic   w_clear;
    logic   w_count_en;
    logic   w_expired;

    assign w_valid    = DM_enable && (DM_read ^ DM_write);
    assign w_conflict = DM_enable && DM_read && DM_write;
    // Holding the timer cleared while idle guarantees a fresh count on entry.
    assign w_clear    = (r_state == S_IDLE);
    assign w_count_en = (r_state == S_BUSY) && !bus_ack;

    assign dm_stall = (r_state == S_BUSY) ||
                      ((r_state == S_IDLE) && w_valid);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .enable  (w_count_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            DM_out    <= '0;
            dm_error  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        bus_we    <= DM_write;
                        bus_addr  <= DM_address;
                        bus_wdata <= DM_in;
                        bus_req   <= 1'b1;
                        r_state   <= S_BUSY;
                    end else if (w_conflict) begin
                        dm_error <= 1'b1;
                    end
                end
                S_BUSY: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_state <= S_DONE;
                        if (!bus_we) begin
                            DM_out <= bus_rdata;
                        end
                    end else if (w_expired) begin
                        bus_req  <= 1'b0;
                        dm_error <= 1'b1;
                        r_state  <= S_DONE;
                        if (!bus_we) begin
                            DM_out <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bridge.sv
// Randomized scoreboard bench for dm_bridge.
// Driver plays core and bus; a negedge monitor checks each completed access.
module tb_dm_bridge;
    import dm_bridge_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DM_enable = 1'b0;
    logic          DM_read = 1'b0;
    logic          DM_write = 1'b0;
    logic [AW-1:0] DM_address = '0;
    logic [DW-1:0] DM_in = '0;
    logic [DW-1:0] DM_out;
    logic          dm_stall;
    logic          dm_error;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = '0;

    dm_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .DM_enable  (DM_enable),
        .DM_read    (DM_read),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out),
        .dm_stall   (dm_stall),
        .dm_error   (dm_error),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] dout;
        logic          err;
        int            busy;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_err = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Core issues one access; the bus acks in BUSY cycle ackk (0 = never).
    task automatic access(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int ackk,
                          input logic [DW-1:0] rd);
        exp_t e;
        bit   hit;
        hit = (ackk >= 1) && (ackk <= TO);
        if (!we) m_dout = hit ? rd : '0;
        if (!hit) m_err = 1'b1;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        e.dout  = m_dout;
        e.err   = m_err;
        e.busy  = hit ? ackk : TO;
        q.push_back(e);
        DM_enable  = 1'b1;
        DM_read    = !we;
        DM_write   = we;
        DM_address = a;
        DM_in      = d;
        @(posedge clk); #1;
        for (int k = 1; k <= TO; k++) begin
            if (k == ackk) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (k == ackk) break;
        end
        DM_enable  = 1'b0;
        DM_read    = 1'b0;
        DM_write   = 1'b0;
        DM_address = AW'($urandom);
        DM_in      = $urandom;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            if (stray && ($urandom_range(0, 2) == 0)) begin
                bus_ack   = 1'b1;
                bus_rdata = $urandom;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
    endtask

    task automatic bad_access(input bit both);
        if (both) m_err = 1'b1;
        DM_enable  = 1'b1;
        DM_read    = both;
        DM_write   = both;
        DM_address = AW'($urandom);
        #1;
        chk("stall_ignored", 32'(dm_stall), 32'd0);
        @(posedge clk); #1;
        chk("req_ignored", 32'(bus_req), 32'd0);
        chk("err_ignored", 32'(dm_error), 32'(m_err));
        DM_enable = 1'b0;
        DM_read   = 1'b0;
        DM_write  = 1'b0;
    endtask

    // Monitor: measures each bus_req window and checks it on the DONE cycle.
    int            busy_n = 0;
    int            stall_n = 0;
    logic          prev_req = 1'b0;
    logic          unstable = 1'b0;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_n   = 0;
            stall_n  = 0;
            prev_req = 1'b0;
            unstable = 1'b0;
        end else begin
            if (bus_req) begin
                if (busy_n == 0) begin
                    cap_we    = bus_we;
                    cap_addr  = bus_addr;
                    cap_wdata = bus_wdata;
                end else if (bus_we !== cap_we || bus_addr !== cap_addr ||
                             bus_wdata !== cap_wdata) begin
                    unstable = 1'b1;
                end
                busy_n++;
            end
            if (dm_stall) stall_n++;
            if (prev_req && !bus_req) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("bus_we", 32'(cap_we), 32'(e.we));
                    chk("bus_addr", 32'(cap_addr), 32'(e.addr));
                    chk("bus_wdata", cap_wdata, e.wdata);
                    chk("bus_stable", 32'(unstable), 32'd0);
                    chk("busy_len", 32'(busy_n), 32'(e.busy));
                    chk("stall_len", 32'(stall_n), 32'(e.busy + 1));
                    chk("stall_done", 32'(dm_stall), 32'd0);
                    chk("dm_out", DM_out, e.dout);
                    chk("dm_error", 32'(dm_error), 32'(e.err));
                end
                busy_n   = 0;
                stall_n  = 0;
                unstable = 1'b0;
            end else if (!dm_stall && !bus_req) begin
                stall_n = 0;
            end
            prev_req = bus_req;
        end
    end

    initial begin
        int r;
        int ackk;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dm_out", DM_out, 32'd0);
        chk("rst_error", 32'(dm_error), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_stall", 32'(dm_stall), 32'd0);
        rst = 1'b1;
        idle(2, 1'b1);

        access(1'b0, 12'h010, 32'd0, 2, 32'hCAFE_0001);
        idle(1, 1'b0);
        access(1'b1, 12'h3FF, 32'h1234_5678, 1, 32'hDEAD_BEEF);
        idle(1, 1'b0);
        access(1'b0, 12'h0A5, 32'd0, TO, 32'h0BAD_F00D);
        idle(2, 1'b0);
        bad_access(1'b0);
        idle(1, 1'b0);
        access(1'b0, 12'h123, 32'd0, 0, 32'd0);
        idle(1, 1'b0);
        bad_access(1'b1);
        idle(1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            ackk = (r == 0) ? 0 :
                   (r == 1) ? TO : $urandom_range(1, TO - 1);
            r = $urandom_range(0, 99);
            if (r < 45) begin
                access(1'b0, AW'($urandom), $urandom, ackk, $urandom);
            end else if (r < 85) begin
                access(1'b1, AW'($urandom), $urandom, ackk, $urandom);
            end else begin
                bad_access(r < 93);
            end
            idle($urandom_range(1, 3), 1'b1);
        end

        DM_enable  = 1'b1;
        DM_read    = 1'b1;
        DM_address = 12'h055;
        @(posedge clk); #1;
        DM_enable = 1'b0;
        DM_read   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("req_before_rst", 32'(bus_req), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy_req", 32'(bus_req), 32'd0);
        chk("rst_busy_err", 32'(dm_error), 32'd0);
        chk("rst_busy_out", DM_out, 32'd0);
        chk("rst_busy_addr", 32'(bus_addr), 32'd0);
        rst    = 1'b1;
        m_dout = '0;
        m_err  = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_req", 32'(bus_req), 32'd0);
        chk("late_ack_out", DM_out, 32'd0);
        access(1'b0, 12'h055, 32'd0, 3, 32'hA5A5_0003);
        idle(4, 1'b0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
